// File: rtl/lc3_ctrl_pkg.sv
// LC-3 pipeline controller shared types and opcode constants.
// LC3_INDIRECT_EN enables the LDI/STI indirect memory path.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    MS_READ  = 2'd0,
    MS_IND   = 2'd1,
    MS_WRITE = 2'd2,
    MS_IDLE  = 2'd3
  } mem_state_t;

  localparam int BR_DRAIN_DEF = 3;
  localparam int STARTUP_DEF  = 4;

`ifdef LC3_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  // Ops whose result is ready at the end of execute.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op == OP_ADD || op == OP_AND ||
           op == OP_NOT || op == OP_LEA;
  endfunction

  // Ops whose result arrives from data memory.
  function automatic logic is_load_op(input logic [3:0] op);
    return op == OP_LD || op == OP_LDR ||
           (IND_EN && op == OP_LDI);
  endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// LC-3 data-memory access sequencer with writeback pulse.
// IND state is reachable only when LC3_INDIRECT_EN is defined.
module lc3_mem_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       go_i,
  input  logic [3:0] op_i,
  input  logic       complete_data_i,
  output mem_state_t state_o,
  output logic       start_o,
  output logic       wb_pulse_o
);

  mem_state_t state_q;
  logic       store_q;
  logic       is_rd;
  logic       is_wr;
  logic       is_ind_rd;
  logic       is_ind_wr;

  assign is_rd     = op_i == OP_LD || op_i == OP_LDR;
  assign is_wr     = op_i == OP_ST || op_i == OP_STR;
  assign is_ind_rd = IND_EN && op_i == OP_LDI;
  assign is_ind_wr = IND_EN && op_i == OP_STI;

  assign start_o = go_i && state_q == MS_IDLE &&
                   (is_rd | is_wr | is_ind_rd | is_ind_wr);

  assign wb_pulse_o = state_q == MS_READ && complete_data_i;
  assign state_o    = state_q;

  // Access sequencer; store_q remembers the direction after IND.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MS_IDLE;
      store_q <= 1'b0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (start_o) begin
            store_q <= is_wr | is_ind_wr;
            unique case (1'b1)
              is_ind_rd,
              is_ind_wr: state_q <= MS_IND;
              is_wr:     state_q <= MS_WRITE;
              default:   state_q <= MS_READ;
            endcase
          end
        end
        MS_IND: begin
          if (complete_data_i)
            state_q <= store_q ? MS_WRITE : MS_READ;
        end
        MS_READ,
        MS_WRITE: begin
          if (complete_data_i)
            state_q <= MS_IDLE;
        end
        default: state_q <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC-3 five-stage pipeline sequencer: startup, branch drain, bypass.
// Build with LC3_INDIRECT_EN to enable LDI/STI indirect accesses.
module lc3_pipe_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int BR_DRAIN       = BR_DRAIN_DEF,
  parameter int STARTUP_STAGES = STARTUP_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_data,
  input  logic        complete_instr,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);

  localparam int SW = $clog2(STARTUP_STAGES + 1);
  localparam int DW = $clog2(BR_DRAIN + 1);

  logic [SW-1:0] st_q;
  logic [DW-1:0] dr_q;
  logic          jmp_q;

  mem_state_t ms;
  logic       mem_go;
  logic       wb_pulse;
  logic       mem_busy;

  logic [3:0] op_d;
  logic [3:0] op_x;
  logic [2:0] dst;

  logic pc_on;
  logic dec_on;
  logic ex_on;
  logic wb_on;
  logic draining;
  logic last;
  logic br_hit;

  logic sr1_use;
  logic sr2_use;
  logic m1;
  logic m2;
  logic unused_bits;

  assign op_d = IR[15:12];
  assign op_x = IR_Exec[15:12];
  assign dst  = IR_Exec[11:9];

  assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0]};

  lc3_mem_fsm u_mem (
    .clock           (clock),
    .reset           (reset),
    .go_i            (ex_on),
    .op_i            (op_x),
    .complete_data_i (complete_data),
    .state_o         (ms),
    .start_o         (mem_go),
    .wb_pulse_o      (wb_pulse)
  );

  assign mem_state = ms;
  assign mem_busy  = ms != MS_IDLE;

  assign pc_on  = st_q >= SW'(1);
  assign dec_on = st_q >= SW'(2);
  assign ex_on  = st_q >= SW'(3);
  assign wb_on  = st_q >= SW'(4);

  assign draining = dr_q != '0;
  assign last     = dr_q == DW'(1) && !mem_busy;

  assign enable_fetch = pc_on && complete_instr &&
                        !mem_busy && !draining;
  assign enable_updatePC = pc_on && complete_instr &&
                           !mem_busy && (!draining || last);
  assign enable_decode = dec_on && complete_instr && !mem_busy;
  assign enable_execute = ex_on && !mem_busy;
  assign enable_writeback = mem_busy ? wb_pulse : wb_on;

  // A load entering execute wins; the branch is picked up later.
  assign br_hit = (op_d == OP_BR || op_d == OP_JMP) &&
                  enable_decode && !mem_go && !draining;

  assign br_taken = last && (jmp_q || |(dst & psr));

  // Staggered enable ramp after reset, saturating.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      st_q <= '0;
    else if (st_q != SW'(STARTUP_STAGES))
      st_q <= st_q + SW'(1);
  end

  // Branch drain countdown, frozen while memory is busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dr_q  <= '0;
      jmp_q <= 1'b0;
    end else if (draining) begin
      if (!mem_busy)
        dr_q <= dr_q - DW'(1);
    end else if (br_hit) begin
      dr_q  <= DW'(BR_DRAIN);
      jmp_q <= op_d == OP_JMP;
    end
  end

  assign sr1_use = op_d == OP_ADD || op_d == OP_AND ||
                   op_d == OP_NOT || op_d == OP_LDR ||
                   op_d == OP_STR || op_d == OP_JMP;
  assign sr2_use = (op_d == OP_ADD || op_d == OP_AND) && !IR[5];

  assign m1 = sr1_use && IR[8:6] == dst;
  assign m2 = sr2_use && IR[2:0] == dst;

  assign bypass_alu_1 = reset && is_alu_op(op_x) && m1;
  assign bypass_alu_2 = reset && is_alu_op(op_x) && m2;
  assign bypass_mem_1 = reset && is_load_op(op_x) && m1 &&
                        !bypass_alu_1;
  assign bypass_mem_2 = reset && is_load_op(op_x) && m2 &&
                        !bypass_alu_2;

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed bench for the LC-3 pipeline controller.
// Expected mem_state paths follow LC3_INDIRECT_EN.
module tb_lc3_pipe_controller;

  logic        clock;
  logic        reset;
  logic        complete_data;
  logic        complete_instr;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  psr;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;
  logic [1:0]  mem_state;

  logic [4:0] en;
  logic [3:0] byp;

  int checks;
  int failures;

  lc3_pipe_controller dut (
    .clock            (clock),
    .reset            (reset),
    .complete_data    (complete_data),
    .complete_instr   (complete_instr),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .psr              (psr),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2),
    .bypass_mem_1     (bypass_mem_1),
    .bypass_mem_2     (bypass_mem_2),
    .mem_state        (mem_state)
  );

  assign en = {enable_updatePC, enable_fetch, enable_decode,
               enable_execute, enable_writeback};
  assign byp = {bypass_alu_1, bypass_alu_2,
                bypass_mem_1, bypass_mem_2};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    complete_data = 1'b0;
    complete_instr = 1'b1;
    IR = 16'h1641;
    IR_Exec = 16'h1262;
    psr = 3'b000;

    // reset state, bypass gated by reset
    nxt(); nxt(); #1;
    chk("rst_en", 16'(en), 16'h00);
    chk("rst_ms", 16'(mem_state), 16'd3);
    chk("rst_br", 16'(br_taken), 16'd0);
    chk("rst_byp", 16'(byp), 16'h0);

    // startup ramp
    reset = 1'b1; #1;
    chk("rel_en", 16'(en), 16'b00000);
    nxt(); #1; chk("st1_en", 16'(en), 16'b11000);
    chk("st1_ms", 16'(mem_state), 16'd3);
    nxt(); #1; chk("st2_en", 16'(en), 16'b11100);
    nxt(); #1; chk("st3_en", 16'(en), 16'b11110);
    chk("st3_ms", 16'(mem_state), 16'd3);
    nxt(); #1; chk("st4_en", 16'(en), 16'b11111);
    nxt(); #1; chk("st5_en", 16'(en), 16'b11111);
    chk("st5_ms", 16'(mem_state), 16'd3);

    // ALU bypass
    chk("byp_add", 16'(byp), 16'b1100);
    nxt(); IR = 16'h1661; #1;
    chk("byp_imm", 16'(byp), 16'b1000);
    nxt(); IR = 16'hE000; #1;
    chk("byp_lea", 16'(byp), 16'b0000);

    // fetch stall
    nxt(); IR = 16'h1641; complete_instr = 1'b0; #1;
    chk("fstall_en", 16'(en), 16'b00011);
    nxt(); complete_instr = 1'b1; #1;
    chk("fstall_rec", 16'(en), 16'b11111);

    // LDR producer: mem bypass, then a one-cycle READ
    nxt(); IR_Exec = 16'h6240; complete_data = 1'b1; #1;
    chk("byp_ldr", 16'(byp), 16'b0011);
    nxt(); IR_Exec = 16'h1262; #1;
    chk("ldr_ms", 16'(mem_state), 16'd0);
    chk("ldr_en", 16'(en), 16'b00001);
    nxt(); #1;
    chk("ldr_idle", 16'(mem_state), 16'd3);

    // LD with two wait cycles
    nxt(); IR_Exec = 16'h2205; complete_data = 1'b0; #1;
    chk("ld0_ms", 16'(mem_state), 16'd3);
    chk("ld0_en", 16'(en), 16'b11111);
    nxt(); IR_Exec = 16'h1262; #1;
    chk("ld1_ms", 16'(mem_state), 16'd0);
    chk("ld1_en", 16'(en), 16'b00000);
    nxt(); #1;
    chk("ld2_ms", 16'(mem_state), 16'd0);
    chk("ld2_en", 16'(en), 16'b00000);
    nxt(); complete_data = 1'b1; #1;
    chk("ld3_ms", 16'(mem_state), 16'd0);
    chk("ld3_en", 16'(en), 16'b00001);
    nxt(); complete_data = 1'b0; #1;
    chk("ld4_ms", 16'(mem_state), 16'd3);
    chk("ld4_en", 16'(en), 16'b11111);

    // STI
    nxt(); IR_Exec = 16'hB405; complete_data = 1'b1; #1;
    chk("sti0_ms", 16'(mem_state), 16'd3);
`ifdef LC3_INDIRECT_EN
    nxt(); IR_Exec = 16'h1262; #1;
    chk("sti1_ms", 16'(mem_state), 16'd1);
    chk("sti1_en", 16'(en), 16'b00000);
    nxt(); #1;
    chk("sti2_ms", 16'(mem_state), 16'd2);
    chk("sti2_en", 16'(en), 16'b00000);
    nxt(); #1;
    chk("sti3_ms", 16'(mem_state), 16'd3);
    chk("sti3_en", 16'(en), 16'b11111);
`else
    nxt(); IR_Exec = 16'h1262; #1;
    chk("sti1_ms", 16'(mem_state), 16'd3);
    chk("sti1_en", 16'(en), 16'b11111);
    nxt(); #1;
    chk("sti2_ms", 16'(mem_state), 16'd3);
`endif

    // BRz taken
    nxt(); complete_data = 1'b0; IR = 16'h0403; psr = 3'b010; #1;
    chk("brt0_en", 16'(en), 16'b11111);
    nxt(); IR = 16'h1641; IR_Exec = 16'h0403; #1;
    chk("brt1_en", 16'(en), 16'b00111);
    chk("brt1_br", 16'(br_taken), 16'd0);
    nxt(); #1;
    chk("brt2_en", 16'(en), 16'b00111);
    nxt(); #1;
    chk("brt3_en", 16'(en), 16'b10111);
    chk("brt3_br", 16'(br_taken), 16'd1);
    nxt(); #1;
    chk("brt4_en", 16'(en), 16'b11111);
    chk("brt4_br", 16'(br_taken), 16'd0);

    // BRz not taken
    nxt(); IR = 16'h0403; IR_Exec = 16'h1262; psr = 3'b100; #1;
    nxt(); IR = 16'h1641; IR_Exec = 16'h0403; #1;
    chk("brn1_en", 16'(en), 16'b00111);
    nxt(); nxt(); #1;
    chk("brn3_en", 16'(en), 16'b10111);
    chk("brn3_br", 16'(br_taken), 16'd0);

    // JMP always redirects
    nxt(); IR = 16'hC1C0; IR_Exec = 16'h1262; psr = 3'b000; #1;
    nxt(); IR = 16'h1641; IR_Exec = 16'h0403; #1;
    nxt(); nxt(); #1;
    chk("jmp3_br", 16'(br_taken), 16'd1);
    nxt(); #1;
    chk("jmp4_br", 16'(br_taken), 16'd0);

    // branch and load together: load first
    nxt(); IR = 16'h0403; IR_Exec = 16'h2205;
    complete_data = 1'b1; psr = 3'b010; #1;
    chk("sim0_en", 16'(en), 16'b11111);
    nxt(); IR_Exec = 16'h1262; #1;
    chk("sim1_ms", 16'(mem_state), 16'd0);
    chk("sim1_en", 16'(en), 16'b00001);
    nxt(); #1;
    chk("sim2_en", 16'(en), 16'b11111);
    nxt(); IR = 16'h1641; IR_Exec = 16'h0403; #1;
    chk("sim3_en", 16'(en), 16'b00111);
    nxt(); nxt(); #1;
    chk("sim5_en", 16'(en), 16'b10111);
    chk("sim5_br", 16'(br_taken), 16'd1);
    nxt(); #1;
    chk("sim6_en", 16'(en), 16'b11111);

    // load arriving mid-drain freezes the countdown
    nxt(); IR = 16'h0403; IR_Exec = 16'h1262; #1;
    nxt(); IR = 16'h1641; IR_Exec = 16'h2205; #1;
    chk("frz1_en", 16'(en), 16'b00111);
    nxt(); IR_Exec = 16'h0403; #1;
    chk("frz2_en", 16'(en), 16'b00001);
    nxt(); #1;
    chk("frz3_en", 16'(en), 16'b00111);
    chk("frz3_br", 16'(br_taken), 16'd0);
    nxt(); #1;
    chk("frz4_en", 16'(en), 16'b10111);
    chk("frz4_br", 16'(br_taken), 16'd1);
    nxt(); #1;
    chk("frz5_en", 16'(en), 16'b11111);

    // asynchronous reset during a memory access
    nxt(); complete_data = 1'b0; IR = 16'h1641;
`ifdef LC3_INDIRECT_EN
    IR_Exec = 16'hB405;
`else
    IR_Exec = 16'h2205;
`endif
    #1;
    nxt(); #1;
`ifdef LC3_INDIRECT_EN
    chk("mid_ms", 16'(mem_state), 16'd1);
`else
    chk("mid_ms", 16'(mem_state), 16'd0);
`endif
    reset = 1'b0; #1;
    chk("arst_en", 16'(en), 16'h00);
    chk("arst_ms", 16'(mem_state), 16'd3);
    chk("arst_br", 16'(br_taken), 16'd0);
    chk("arst_byp", 16'(byp), 16'h0);
    nxt(); IR_Exec = 16'h1262; reset = 1'b1; #1;
    chk("rs0_en", 16'(en), 16'b00000);
    nxt(); #1;
    chk("rs1_en", 16'(en), 16'b11000);
    chk("rs1_ms", 16'(mem_state), 16'd3);
    nxt(); #1;
    chk("rs2_en", 16'(en), 16'b11100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
